prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Sits directly upstream of the multicycle CPU (control unit + datapath) and owns the unified instruction/data memory port.
- After reset, or on a start request, holds the CPU in reset and copies a program image word-by-word from a synchronous boot ROM into memory.
- When the copy is complete, releases the CPU and passes the CPU's memory requests straight through to memory.

Parameters:
- ADDR_W, 8, memory/ROM word-address width.
- DATA_W, 32, word width.
- WORDS, 64, number of words copied; must satisfy 1 <= WORDS <= 2**ADDR_W.
- START_ADDR, 0, memory word address that receives ROM word 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to (re)load the program.
- rom_addr  out  ADDR_W  boot ROM address; the ROM registers it, and data appears the next cycle.
- rom_data  in  DATA_W  boot ROM read data.
- cpu_addr  in  ADDR_W  CPU memory address (IorD-selected).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU MemWrite.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- cpu_run  out  1  1 = CPU released; the CPU's reset is driven from this.
- busy  out  1  copy in progress.
- done  out  1  one-cycle pulse when the last word has been written.

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-low.
- State encoding: IDLE, READ, WRITE, FINISH, RUN, held in a state register plus an index counter idx (ADDR_W bits).
- Reset state: state = IDLE, idx = 0, cpu_run = 0, busy = 0, done = 0, mem_we = 0.
- Reset taken mid-copy: aborts the copy immediately; the partially written memory contents are don't-care.
- IDLE:
  - cpu_run = 0; memory port quiescent (mem_we = 0).
  - start = 1 -> READ, idx <= 0.
- READ:
  - busy = 1, rom_addr = idx, mem_we = 0.
  - Unconditionally -> WRITE.
- WRITE:
  - busy = 1, mem_we = 1, mem_addr = (START_ADDR + idx) mod 2**ADDR_W, mem_wdata = rom_data.
  - If idx == WORDS-1 -> FINISH; otherwise idx <= idx+1 and -> READ.
- FINISH:
  - done = 1 for this cycle only, busy = 0, mem_we = 0.
  - -> RUN.
- RUN:
  - cpu_run = 1.
  - mem_addr/mem_wdata/mem_we are combinational pass-throughs of cpu_addr/cpu_wdata/cpu_we.
  - start = 1 -> READ, idx <= 0, cpu_run drops to 0 in the same edge (reload with the CPU held).
- start while busy (READ/WRITE/FINISH): ignored; the copy neither restarts nor extends.
- Outside RUN, cpu_we/cpu_addr/cpu_wdata are ignored and must never reach memory.
- rom_addr = idx in every state; its value outside READ is don't-care.
- Latency: 2 cycles per word; done asserts 2*WORDS cycles after the start cycle; cpu_run rises 1 cycle after done.
- Address wrap: START_ADDR + idx wraps modulo 2**ADDR_W with no error.
- idx never exceeds WORDS-1.
- Outputs in IDLE/READ/WRITE/FINISH are registered-state decodes; the only combinational paths are the RUN pass-throughs and rom_addr.

Decomposition:
- Shared package cpu_pkg:
  - Loader state enum (IDLE, READ, WRITE, FINISH, RUN).
  - Default ADDR_W/DATA_W, matching the datapath memory.
- Sub-module: none needed.
- The memory-port mux may be written as a small combinational block inside prog_loader; do not split it out.

Test Plan (WORDS=4, START_ADDR=8, ADDR_W=8 unless noted):
- Reset low then high, start never asserted -> cpu_run=0, mem_we=0 indefinitely; cpu_we=1 with cpu_addr=3 causes no memory write.
- Pulse start, ROM holds A0,A1,A2,A3 -> mem_we pulses on alternate cycles writing addr 8,9,10,11 with data A0..A3; done pulses 8 cycles after start; cpu_run=1 the following cycle.
- In RUN, drive cpu_addr=0x20, cpu_wdata=0xDEADBEEF, cpu_we=1 -> mem_* equal those values in the same cycle.
- START_ADDR=254 -> writes go to addresses 254, 255, 0, 1 (wrap).
- Start re-pulsed during WRITE of word 1 -> ignored; exactly 4 writes and a single done pulse. Start pulsed in RUN -> cpu_run falls on the next edge and a full 4-word reload occurs.
- Reset asserted during READ of word 2 -> all outputs return to reset values asynchronously (before the next clk edge); after release the loader sits in IDLE with cpu_run=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: loader state encoding and default memory geometry.
package cpu_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FINISH,
    RUN
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: copies a ROM image into the unified memory, then releases
// the CPU and hands it the memory port.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int WORDS      = 64,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_run,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(WORDS - 1);

  ld_state_e         r_state;
  ld_state_e         w_next_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_next_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = READ;
          w_next_idx   = '0;
        end
      end
      READ: w_next_state = WRITE;
      WRITE: begin
        if (r_idx == L_LAST) begin
          w_next_state = FINISH;
        end else begin
          w_next_state = READ;
          w_next_idx   = r_idx + 1'b1;
        end
      end
      FINISH: w_next_state = RUN;
      RUN: begin
        // Reload drops cpu_run on the same edge, holding the CPU in reset.
        if (start) begin
          w_next_state = READ;
          w_next_idx   = '0;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = L_BASE + r_idx;
        mem_wdata = rom_data;
      end
      RUN: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign rom_addr = r_idx;
  assign busy     = (r_state == READ) || (r_state == WRITE);
  assign done     = (r_state == FINISH);
  assign cpu_run  = (r_state == RUN);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 8 and wrapping base 254)
// checked against a list-of-writes model of the copy.
module tb_prog_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int BASE_A = 8;
  localparam int BASE_B = 254;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;

  logic [AW-1:0] a_rom_addr, b_rom_addr;
  logic [DW-1:0] a_rom_data, b_rom_data;
  logic [AW-1:0] a_mem_addr, b_mem_addr;
  logic [DW-1:0] a_mem_wdata, b_mem_wdata;
  logic          a_mem_we, b_mem_we;
  logic          a_run, b_run, a_busy, b_busy, a_done, b_done;

  logic [DW-1:0] rom [256];

  int n_tot = 0;
  int n_pass = 0;
  int cyc = 0;
  int a_done_n = 0, b_done_n = 0;
  int a_done_cyc = 0, b_done_cyc = 0;
  logic [AW-1:0] qa_addr[$], qb_addr[$];
  logic [DW-1:0] qa_data[$], qb_data[$];

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS(NW), .START_ADDR(BASE_A)
  ) u_a (
    .clk(clk), .reset(rst_n), .start(start),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .cpu_run(a_run), .busy(a_busy), .done(a_done)
  );

  prog_loader #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS(NW), .START_ADDR(BASE_B)
  ) u_b (
    .clk(clk), .reset(rst_n), .start(start),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .cpu_run(b_run), .busy(b_busy), .done(b_done)
  );

  // Synchronous boot ROMs
  always @(posedge clk) begin
    a_rom_data <= rom[a_rom_addr];
    b_rom_data <= rom[b_rom_addr];
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (a_busy && a_mem_we) begin
      qa_addr.push_back(a_mem_addr);
      qa_data.push_back(a_mem_wdata);
    end
    if (b_busy && b_mem_we) begin
      qb_addr.push_back(b_mem_addr);
      qb_data.push_back(b_mem_wdata);
    end
    if (a_done) begin a_done_n++; a_done_cyc = cyc; end
    if (b_done) begin b_done_n++; b_done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_image();
    for (int i = 0; i < NW; i++) rom[i] = $urandom;
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
    a_done_n = 0; b_done_n = 0;
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic noise_cpu();
    cpu_we    = 1'b1;
    cpu_addr  = AW'($urandom);
    cpu_wdata = $urandom;
  endtask

  // Waits for release and compares both write logs with the image.
  task automatic finish_load(input string tag, input int t0);
    int run_cyc = -1;
    int n;
    for (int k = 0; k < 60; k++) begin
      noise_cpu();
      tick();
      if (a_run === 1'b1) begin run_cyc = cyc; break; end
    end
    cpu_we = 1'b0;
    repeat (6) tick();
    chk({tag, "_run_lat"}, 64'(run_cyc - t0), 64'(2 * NW + 1));
    chk({tag, "_done_lat"}, 64'(a_done_cyc - t0), 64'(2 * NW));
    chk({tag, "_done_n"}, 64'(a_done_n), 64'd1);
    chk({tag, "_b_done_n"}, 64'(b_done_n), 64'd1);
    chk({tag, "_b_run"}, 64'(b_run), 64'd1);
    chk({tag, "_a_nwr"}, 64'(qa_addr.size()), 64'(NW));
    chk({tag, "_b_nwr"}, 64'(qb_addr.size()), 64'(NW));
    n = (qa_addr.size() < NW) ? qa_addr.size() : NW;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_a_addr%0d", tag, i), 64'(qa_addr[i]),
          64'((BASE_A + i) % 256));
      chk($sformatf("%s_a_data%0d", tag, i), 64'(qa_data[i]), 64'(rom[i]));
    end
    n = (qb_addr.size() < NW) ? qb_addr.size() : NW;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_b_addr%0d", tag, i), 64'(qb_addr[i]),
          64'((BASE_B + i) % 256));
      chk($sformatf("%s_b_data%0d", tag, i), 64'(qb_data[i]), 64'(rom[i]));
    end
  endtask

  initial begin
    int t0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 8'd3;
    cpu_wdata = 32'h1234_5678;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) tick();
    chk("rst_run", 64'(a_run), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_we", 64'(a_mem_we), 64'd0);

    // Idle with no start: CPU writes must not leak
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("idle_run%0d", k), 64'(a_run), 64'd0);
      chk($sformatf("idle_we%0d", k), 64'(a_mem_we | b_mem_we), 64'd0);
    end

    // First load
    new_image();
    pulse_start(t0);
    finish_load("load1", t0);

    // Pass-through in RUN, same cycle
    cpu_addr = 8'h20; cpu_wdata = 32'hDEAD_BEEF; cpu_we = 1'b1;
    #1;
    chk("pt_addr", 64'(a_mem_addr), 64'h20);
    chk("pt_data", 64'(a_mem_wdata), 64'hDEAD_BEEF);
    chk("pt_we", 64'(a_mem_we), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      cpu_addr  = AW'($urandom);
      cpu_wdata = $urandom;
      cpu_we    = 1'($urandom);
      #1;
      chk($sformatf("pt_r_addr%0d", k), 64'(b_mem_addr), 64'(cpu_addr));
      chk($sformatf("pt_r_data%0d", k), 64'(b_mem_wdata), 64'(cpu_wdata));
      chk($sformatf("pt_r_we%0d", k), 64'(b_mem_we), 64'(cpu_we));
    end
    cpu_we = 1'b0;

    // Reload from RUN with start re-pulsed during WRITE of word 1
    tick();
    new_image();
    pulse_start(t0);
    chk("reload_run_drop", 64'(a_run), 64'd0);
    repeat (3) tick();
    chk("w1_busy", 64'(a_busy & a_mem_we), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_load("reload", t0);

    // Asynchronous reset during READ of word 2
    new_image();
    pulse_start(t0);
    repeat (4) tick();
    chk("r2_read", 64'(a_busy & ~a_mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run", 64'(a_run | b_run), 64'd0);
    chk("arst_busy", 64'(a_busy | b_busy), 64'd0);
    chk("arst_done", 64'(a_done | b_done), 64'd0);
    chk("arst_we", 64'(a_mem_we | b_mem_we), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    qa_addr.delete(); qb_addr.delete();
    cpu_we = 1'b1; cpu_addr = 8'd3;
    repeat (4) tick();
    chk("post_run", 64'(a_run), 64'd0);
    chk("post_busy", 64'(a_busy), 64'd0);
    chk("post_we", 64'(a_mem_we), 64'd0);
    chk("post_nwr", 64'(qa_addr.size() + qb_addr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
